// File: rtl/fetch_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_seq_if : request/status bundle between a controller and the    |
// |                fetch_seq program-counter sequencer                   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface fetch_seq_if #(
  parameter int PC_W      = 10,
  parameter int NUM_PROGS = 2
);
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic [SEL_W-1:0] ProgState;
  logic             Stall;
  logic             Branch_en;
  logic             FLAG_IN;
  logic             Rel;
  logic [PC_W-1:0]  Target;
  logic             Call_en;
  logic             Ret_en;
  logic [PC_W-1:0]  PC;
  logic             Halt;
  logic             Running;
  logic [SEL_W-1:0] CurProg;

  modport master (
    output ProgState, Stall, Branch_en, FLAG_IN, Rel, Target, Call_en, Ret_en,
    input  PC, Halt, Running, CurProg
  );

  modport slave (
    input  ProgState, Stall, Branch_en, FLAG_IN, Rel, Target, Call_en, Ret_en,
    output PC, Halt, Running, CurProg
  );
endinterface
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_seq : program-counter sequencer with selectable programs,      |
// |             stall, absolute/relative branches and end-of-program halt|
// |             FETCH_LINK_EN adds a one-deep call/return link register. |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module fetch_seq #(
  parameter int                          PC_W        = 10,
  parameter int                          NUM_PROGS   = 2,
  parameter logic [NUM_PROGS*PC_W-1:0]   START_ADDRS = {10'd27, 10'd0},
  parameter logic [NUM_PROGS*PC_W-1:0]   END_ADDRS   = {10'd141, 10'd26}
) (
  input  logic         CLK,
  input  logic         Init,
  fetch_seq_if.slave   bus
);
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Declaration values give the power-up state seen before the first Init.
  logic [1:0]       state_q = ST_LOAD;
  logic [1:0]       state_d;
  logic [PC_W-1:0]  pc_q    = '0;
  logic [PC_W-1:0]  pc_d;
  logic             halt_q  = 1'b0;
  logic             halt_d;
  logic [SEL_W-1:0] cur_q   = '0;
  logic [SEL_W-1:0] cur_d;

  logic             w_prog_ok;
  logic [PC_W-1:0]  w_start_sel;
  logic [PC_W-1:0]  w_end_cur;
  logic [PC_W-1:0]  w_branch_pc;
  logic             w_call;
  logic             w_ret;
  logic [PC_W-1:0]  w_ret_pc;

  assign w_prog_ok   = 32'(bus.ProgState) < NUM_PROGS;
  assign w_branch_pc = bus.Rel ? (pc_q + bus.Target) : bus.Target;

  always_comb begin
    w_start_sel = '0;
    w_end_cur   = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (bus.ProgState == SEL_W'(i))
        w_start_sel = START_ADDRS[i*PC_W +: PC_W];
      if (cur_q == SEL_W'(i))
        w_end_cur = END_ADDRS[i*PC_W +: PC_W];
    end
  end

`ifdef FETCH_LINK_EN
  logic [PC_W-1:0] link_q = '0;
  logic [PC_W-1:0] link_d;

  assign w_call   = bus.Call_en;
  assign w_ret    = bus.Ret_en;
  assign w_ret_pc = link_q;

  always_comb begin
    link_d = link_q;
    if (Init)
      link_d = '0;
    else if (state_q == ST_RUN && !bus.Stall && bus.Call_en)
      link_d = pc_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    link_q <= link_d;
  end
`else
  logic w_unused_link;

  assign w_call        = 1'b0;
  assign w_ret         = 1'b0;
  assign w_ret_pc      = '0;
  assign w_unused_link = bus.Call_en ^ bus.Ret_en;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    cur_d   = cur_q;
    if (Init) begin
      state_d = ST_LOAD;
      halt_d  = 1'b0;
      cur_d   = w_prog_ok ? bus.ProgState : '0;
      pc_d    = w_prog_ok ? w_start_sel : '0;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (!bus.Stall) begin
            if (w_call)
              pc_d = bus.Target;
            else if (w_ret)
              pc_d = w_ret_pc;
            else if (bus.Branch_en && bus.FLAG_IN)
              pc_d = w_branch_pc;
            else if (pc_q == w_end_cur) begin
              halt_d  = 1'b1;
              state_d = ST_DONE;
            end else
              pc_d = pc_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    halt_q  <= halt_d;
    cur_q   <= cur_d;
  end

  assign bus.PC      = pc_q;
  assign bus.Halt    = halt_q;
  assign bus.Running = (state_q == ST_RUN);
  assign bus.CurProg = cur_q;
endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_seq : vector table, directed corner sequences and random    |
// |                stimulus against a behavioural model of fetch_seq     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fetch_seq;
  logic CLK = 1'b0;
  logic init_a;
  logic init_b;
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef FETCH_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  always #5 CLK = ~CLK;

  fetch_seq_if #(.PC_W(10), .NUM_PROGS(2)) bus_a ();
  fetch_seq_if #(.PC_W(4),  .NUM_PROGS(3)) bus_b ();

  fetch_seq #(.PC_W(10), .NUM_PROGS(2)) u_a (
    .CLK  (CLK),
    .Init (init_a),
    .bus  (bus_a)
  );

  // Program 0 starts past its end address so the PC must wrap to reach it.
  fetch_seq #(
    .PC_W        (4),
    .NUM_PROGS   (3),
    .START_ADDRS (12'h50E),
    .END_ADDRS   (12'h538)
  ) u_b (
    .CLK  (CLK),
    .Init (init_b),
    .bus  (bus_b)
  );

  typedef struct {
    bit init; int prog; bit stall; bit br; bit flag; bit rel; int tgt;
    int pc; bit halt; bit run; int cur;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference of unit A.
  int m_pc, m_cur, m_link;
  bit m_halt, m_load, m_done;
  int m_start[2] = '{0, 27};
  int m_end[2]   = '{26, 141};

  function automatic vec_t v(bit init, int prog, bit stall, bit br, bit flag, bit rel,
                             int tgt, int pc, bit halt, bit run, int cur);
    vec_t r;
    r.init = init; r.prog = prog; r.stall = stall; r.br = br; r.flag = flag;
    r.rel = rel; r.tgt = tgt; r.pc = pc; r.halt = halt; r.run = run; r.cur = cur;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input bit init, input int prog, input bit stall, input bit br,
                         input bit flag, input bit rel, input int tgt,
                         input bit call, input bit ret);
    init_a          = init;
    bus_a.ProgState = prog[0:0];
    bus_a.Stall     = stall;
    bus_a.Branch_en = br;
    bus_a.FLAG_IN   = flag;
    bus_a.Rel       = rel;
    bus_a.Target    = tgt[9:0];
    bus_a.Call_en   = call;
    bus_a.Ret_en    = ret;
  endtask

  task automatic model_step();
    int p;
    p = int'(bus_a.ProgState);
    if (init_a) begin
      m_cur  = (p < 2) ? p : 0;
      m_pc   = (p < 2) ? m_start[p] : 0;
      m_halt = 0; m_load = 1; m_done = 0; m_link = 0;
    end else if (m_load) begin
      m_load = 0;
    end else if (!m_done && !bus_a.Stall) begin
      if (LINK && bus_a.Call_en) begin
        m_link = (m_pc + 1) % 1024;
        m_pc   = int'(bus_a.Target);
      end else if (LINK && bus_a.Ret_en) begin
        m_pc = m_link;
      end else if (bus_a.Branch_en && bus_a.FLAG_IN) begin
        m_pc = bus_a.Rel ? (m_pc + int'(bus_a.Target)) % 1024 : int'(bus_a.Target);
      end else if (m_pc == m_end[m_cur]) begin
        m_halt = 1; m_done = 1;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  initial begin
    int exp_b[$];

    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0);
    init_b = 1'b1;
    bus_b.ProgState = '0; bus_b.Stall = 0; bus_b.Branch_en = 0; bus_b.FLAG_IN = 0;
    bus_b.Rel = 0; bus_b.Target = '0; bus_b.Call_en = 0; bus_b.Ret_en = 0;
    #2;

    // ---------------- vector table on unit A ----------------
    vecs.push_back(v(1, 1, 0, 0, 0, 0,    0,  27, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0,  27, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0,  28, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0,    5,   5, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 1022,   3, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0,    5,   5, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 1022,   6, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0,    5,   5, 0, 1, 1));
    vecs.push_back(v(0, 0, 1, 1, 1, 0,    9,   5, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0,  140, 140, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 141, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 1, 0,  140, 140, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 141, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0,    0, 141, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 1, 1, 0,    3, 141, 1, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive_a(vecs[i].init, vecs[i].prog, vecs[i].stall, vecs[i].br, vecs[i].flag,
              vecs[i].rel, vecs[i].tgt, 0, 0);
      tick();
      check($sformatf("vec%0d_pc", i),   bus_a.PC,      vecs[i].pc);
      check($sformatf("vec%0d_halt", i), bus_a.Halt,    vecs[i].halt);
      check($sformatf("vec%0d_run", i),  bus_a.Running, vecs[i].run);
      check($sformatf("vec%0d_cur", i),  bus_a.CurProg, vecs[i].cur);
    end

    // ---------------- program 0 free run, then held in DONE ----------------
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 26; k++) begin
      tick();
      check($sformatf("run0_pc%0d", k), bus_a.PC, k);
    end
    tick();
    check("run0_halt", bus_a.Halt, 1);
    check("run0_halt_pc", bus_a.PC, 26);
    drive_a(0, 0, 0, 1, 1, 0, 3, 1, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("done_hold_pc%0d", k), bus_a.PC, 26);
      check($sformatf("done_hold_halt%0d", k), bus_a.Halt, 1);
    end

    // ---------------- call / return (ignored without the link option) -------
    drive_a(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 1, 1, 0, 10, 0, 0); tick();
    check("link_pre_pc", bus_a.PC, 10);
    drive_a(0, 0, 0, 0, 0, 0, 40, 1, 0); tick();
    check("call_pc", bus_a.PC, LINK ? 40 : 11);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("ret_pc", bus_a.PC, LINK ? 11 : 12);
    drive_a(0, 0, 0, 0, 0, 0, 77, 1, 1); tick();
    check("callret_pc", bus_a.PC, LINK ? 77 : 13);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    check("ret2_pc", bus_a.PC, LINK ? 12 : 14);

    // ---------------- unit B: wrap past 2^PC_W-1, out-of-range select -------
    bus_b.ProgState = 2'd0; init_b = 1'b1; tick();
    check("b_load_pc", bus_b.PC, 14);
    init_b = 1'b0;
    exp_b = '{14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    foreach (exp_b[i]) begin
      tick();
      check($sformatf("b_wrap_pc%0d", i), bus_b.PC, exp_b[i]);
      check($sformatf("b_wrap_halt%0d", i), bus_b.Halt, 0);
    end
    tick();
    check("b_end_halt", bus_b.Halt, 1);
    check("b_end_pc", bus_b.PC, 8);
    bus_b.ProgState = 2'd3; init_b = 1'b1; tick();
    check("b_oor_pc", bus_b.PC, 0);
    check("b_oor_halt", bus_b.Halt, 0);
    check("b_oor_cur", bus_b.CurProg, 0);
    check("b_oor_run", bus_b.Running, 0);
    bus_b.ProgState = 2'd2; tick();
    check("b_prog2_pc", bus_b.PC, 5);
    check("b_prog2_cur", bus_b.CurProg, 2);
    init_b = 1'b0;

    // ---------------- random stimulus on A against the model ----------------
    drive_a(1, $urandom_range(0, 1), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0)
        drive_a(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 160),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      model_step();
      tick();
      check($sformatf("rand%0d", k),
            {bus_a.PC, bus_a.Halt, bus_a.Running, bus_a.CurProg},
            {m_pc[9:0], m_halt, !m_load && !m_done, m_cur[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
